noc_output_arbiter: RTL and testbench

Synchronous, packet-locking round-robin arbiter for one NoC router output channel. It lets N input ports share one output latch stage and drives that stage with a 2-phase (transition-signalled) request/acknowledge handshake. Once a head flit wins, the grant is held until the tail flit has been acknowledged, so packets are never interleaved. The block sits between the input buffers and the output-port latch controller chain; `grant` is the select for the output data mux.

---
 rtl/noc_output_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_noc_output_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_output_arbiter
//
// Packet-locking round-robin arbiter for one NoC router output channel.
// N input ports share one output latch stage. The winner's flits are handed
// downstream with a 2-phase (transition-signalled) request/acknowledge
// handshake. After a head flit wins, the grant stays with that input until its
// tail flit is acknowledged, so packets are never interleaved.
//
// Parameters
//   N_PORTS   : number of requesting inputs
//   PTR_INIT  : index that has highest priority after reset
//   MAX_FLITS : longest legal packet; longer packets set err_overlen
//
// Ports
//   clk         : clock, rising edge
//   preset      : asynchronous active-high reset
//   req         : per-input level valid (a flit is waiting)
//   tail        : per-input "waiting flit is the last of its packet"
//   grant       : one-hot or zero output mux select (registered)
//   in_ack      : one-cycle pulse, granted input's flit consumed (registered)
//   out_req     : 2-phase request to the output stage, toggles once per flit
//   out_ack     : 2-phase acknowledge from the output stage (already in clk)
//   busy        : grant is non-zero (combinational from registered grant)
//   err_overlen : sticky, a packet exceeded MAX_FLITS
// -----------------------------------------------------------------------------
module noc_output_arbiter #(
  parameter int N_PORTS   = 5,
  parameter int PTR_INIT  = 0,
  parameter int MAX_FLITS = 16
) (
  input  logic               clk,
  input  logic               preset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  output logic [N_PORTS-1:0] grant,
  output logic [N_PORTS-1:0] in_ack,
  output logic               out_req,
  input  logic               out_ack,
  output logic               busy,
  output logic               err_overlen
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(MAX_FLITS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_FLITS);
  localparam logic [PW-1:0] PTR_RST  = PW'(PTR_INIT);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [N_PORTS-1:0]   grant_q, grant_d;
  logic [N_PORTS-1:0]   in_ack_q, in_ack_d;
  logic                 out_req_q, out_req_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic                 tail_q, tail_d;
  logic [CW-1:0]        flit_cnt_q, flit_cnt_d;
  logic                 err_overlen_q, err_overlen_d;

  logic                 pick_found;
  logic [PW-1:0]        pick_idx;
  logic [N_PORTS-1:0]   pick_oh;

  // Round-robin pick: first requesting index scanning upward from ptr, wrapping.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand = (int'(ptr_q) + i) % N_PORTS;
      if (!pick_found && req[PW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(cand);
      end else begin
        pick_found = pick_found;
      end
    end
    if (pick_found) begin
      pick_oh[pick_idx] = 1'b1;
    end else begin
      pick_oh = '0;
    end
  end

  // Next-state and output logic of the arbitration / handshake FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    in_ack_d      = '0;
    out_req_d     = out_req_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    tail_d        = tail_q;
    flit_cnt_d    = flit_cnt_q;
    err_overlen_d = err_overlen_q;

    case (state_q)
      ST_IDLE: begin
        // A high in_ack here is the dead cycle after a tail acknowledge:
        // upstream has not yet had a chance to update req.
        if (pick_found && (in_ack_q == '0)) begin
          grant_d    = pick_oh;
          owner_d    = pick_idx;
          tail_d     = tail[pick_idx];
          out_req_d  = ~out_req_q;
          flit_cnt_d = CW'(1);
          state_d    = ST_WAIT_ACK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_ACK: begin
        // grant and out_req are held so the bundled data stays valid.
        if (out_ack == out_req_q) begin
          in_ack_d = grant_q;
          if (!tail_q && (flit_cnt_q == CNT_MAX)) begin
            err_overlen_d = 1'b1;
          end else begin
            err_overlen_d = err_overlen_q;
          end
          if (tail_q) begin
            grant_d = '0;
            ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end

      ST_HOLD: begin
        // Ignore req while in_ack is still high: that req may be the stale
        // flit that was just consumed.
        if ((in_ack_q == '0) && req[owner_q]) begin
          tail_d    = tail[owner_q];
          out_req_d = ~out_req_q;
          if (flit_cnt_q != CNT_MAX) begin
            flit_cnt_d = flit_cnt_q + CW'(1);
          end else begin
            flit_cnt_d = flit_cnt_q;
          end
          state_d = ST_WAIT_ACK;
        end else begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        flit_cnt_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      in_ack_q      <= '0;
      out_req_q     <= 1'b0;
      ptr_q         <= PTR_RST;
      owner_q       <= '0;
      tail_q        <= 1'b0;
      flit_cnt_q    <= '0;
      err_overlen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      in_ack_q      <= in_ack_d;
      out_req_q     <= out_req_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      tail_q        <= tail_d;
      flit_cnt_q    <= flit_cnt_d;
      err_overlen_q <= err_overlen_d;
    end
  end

  assign grant       = grant_q;
  assign in_ack      = in_ack_q;
  assign out_req     = out_req_q;
  assign err_overlen = err_overlen_q;
  assign busy        = (grant_q != '0);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_output_arbiter
//
// Self-checking bench. Upstream inputs are modelled as per-input packet
// sources (packet length, total flits) that advance on in_ack; the output
// stage either echoes out_req straight back or is driven by hand to stall.
// Expected grants are queued when a scenario is set up and popped on every
// out_req transition.
// -----------------------------------------------------------------------------
module tb_noc_output_arbiter;

  localparam int N    = 5;
  localparam int MAXF = 4;

  logic         clk;
  logic         preset;
  logic [N-1:0] req;
  logic [N-1:0] tail;
  logic [N-1:0] grant;
  logic [N-1:0] in_ack;
  logic         out_req;
  logic         out_ack;
  logic         busy;
  logic         err_overlen;

  int           checks;
  int           failures;
  int           cyc;
  logic [N-1:0] exp_q[$];
  int           sent[N];
  int           total[N];
  int           plen[N];
  logic         auto_ack;
  logic         prev_out_req;
  logic         tog;

  noc_output_arbiter #(
    .N_PORTS  (N),
    .PTR_INIT (0),
    .MAX_FLITS(MAXF)
  ) dut (
    .clk        (clk),
    .preset     (preset),
    .req        (req),
    .tail       (tail),
    .grant      (grant),
    .in_ack     (in_ack),
    .out_req    (out_req),
    .out_ack    (out_ack),
    .busy       (busy),
    .err_overlen(err_overlen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N-1:0] oh(input int i);
    return N'(1) << i;
  endfunction

  // One clock: wait for the falling edge, note any out_req transition, let
  // the upstream sources react to in_ack, and echo out_ack if enabled.
  task automatic tick();
    @(negedge clk);
    cyc++;
    tog          = (out_req !== prev_out_req);
    prev_out_req = out_req;
    for (int i = 0; i < N; i++) begin
      if (in_ack[i] === 1'b1) begin
        sent[i]++;
        if (sent[i] >= total[i]) begin
          req[i]  = 1'b0;
          tail[i] = 1'b0;
        end else begin
          tail[i] = (((sent[i] + 1) % plen[i]) == 0);
        end
      end
    end
    if (auto_ack) out_ack = out_req;
  endtask

  task automatic settle();
    repeat (5) tick();
  endtask

  task automatic start_pkt(input int i, input int len, input int tot);
    sent[i]  = 0;
    total[i] = tot;
    plen[i]  = len;
    req[i]   = 1'b1;
    tail[i]  = (len == 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      sent[i]  = 0;
      total[i] = 0;
      plen[i]  = 1;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    preset   = 1'b1;
    req      = '0;
    tail     = '0;
    out_ack  = 1'b0;
    auto_ack = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    checks++; if (grant !== 5'b00000) begin failures++; $display("FAIL reset_grant got=%b exp=%b", grant, 5'b00000); end
    checks++; if (in_ack !== 5'b00000) begin failures++; $display("FAIL reset_in_ack got=%b exp=%b", in_ack, 5'b00000); end
    checks++; if (out_req !== 1'b0) begin failures++; $display("FAIL reset_out_req got=%b exp=0", out_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_overlen !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_overlen); end
    preset       = 1'b0;
    prev_out_req = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] e;
    logic         exp_or;
    int           n;
    int           last;
    n        = 0;
    last     = 0;
    auto_ack = 1'b1;
    for (int i = 0; i < N; i++) start_pkt(i, 1, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_q.push_back(oh(i));
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) begin
      tick();
      if (tog) begin
        e = exp_q.pop_front();
        checks++; if (grant !== e) begin failures++; $display("FAIL rr_grant n=%0d got=%b exp=%b", n, grant, e); end
        exp_or = ((n % 2) == 0);
        checks++; if (out_req !== exp_or) begin failures++; $display("FAIL rr_out_req n=%0d got=%b exp=%b", n, out_req, exp_or); end
        if (n > 0) begin
          checks++; if ((cyc - last) != 3) begin failures++; $display("FAIL rr_period n=%0d got=%0d exp=3", n, cyc - last); end
        end
        last = cyc;
        n++;
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL rr_timeout got=%0d_pending exp=0", exp_q.size());
      exp_q.delete();
    end
    settle();
  endtask

  task automatic test_single();
    logic [N-1:0] e;
    auto_ack = 1'b1;
    start_pkt(2, 1, 1);
    exp_q.push_back(5'b00100);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant !== e) begin failures++; $display("FAIL single_grant got=%b exp=%b", grant, e); end
    checks++; if (out_req !== 1'b1) begin failures++; $display("FAIL single_out_req got=%b exp=1", out_req); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    checks++; if (in_ack !== 5'b00100) begin failures++; $display("FAIL single_in_ack got=%b exp=%b", in_ack, 5'b00100); end
    checks++; if (grant !== 5'b00000) begin failures++; $display("FAIL single_grant_clr got=%b exp=%b", grant, 5'b00000); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_clr got=%b exp=0", busy); end
    tick();
    checks++; if (in_ack !== 5'b00000) begin failures++; $display("FAIL single_in_ack_pulse got=%b exp=%b", in_ack, 5'b00000); end
    checks++; if (dut.ptr_q !== 3'd3) begin failures++; $display("FAIL single_ptr got=%0d exp=3", dut.ptr_q); end
    settle();
  endtask

  task automatic test_packet_lock();
    logic [N-1:0] e;
    auto_ack = 1'b1;
    start_pkt(1, 4, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(5'b00010);
    exp_q.push_back(5'b01000);
    for (int t = 0; t < 100 && exp_q.size() > 0; t++) begin
      tick();
      if (t == 0) start_pkt(3, 1, 1);
      if (tog) begin
        e = exp_q.pop_front();
        checks++; if (grant !== e) begin failures++; $display("FAIL lock_grant got=%b exp=%b", grant, e); end
      end
      if (sent[1] < 4) begin
        checks++; if (grant !== 5'b00010) begin failures++; $display("FAIL lock_held got=%b exp=%b", grant, 5'b00010); end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL lock_timeout got=%0d_pending exp=0", exp_q.size());
      exp_q.delete();
    end
    settle();
  endtask

  task automatic test_stall();
    logic [N-1:0] e;
    logic         exp_or;
    auto_ack = 1'b0;
    exp_or   = ~prev_out_req;
    start_pkt(4, 1, 1);
    exp_q.push_back(5'b10000);
    tick();
    e = exp_q.pop_front();
    checks++; if (grant !== e) begin failures++; $display("FAIL stall_grant got=%b exp=%b", grant, e); end
    checks++; if (out_req !== exp_or) begin failures++; $display("FAIL stall_toggle got=%b exp=%b", out_req, exp_or); end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (grant !== 5'b10000) begin failures++; $display("FAIL stall_grant_hold k=%0d got=%b exp=%b", k, grant, 5'b10000); end
      checks++; if (out_req !== exp_or) begin failures++; $display("FAIL stall_out_req_hold k=%0d got=%b exp=%b", k, out_req, exp_or); end
      checks++; if (in_ack !== 5'b00000) begin failures++; $display("FAIL stall_in_ack k=%0d got=%b exp=%b", k, in_ack, 5'b00000); end
    end
    out_ack = exp_or;
    tick();
    checks++; if (in_ack !== 5'b10000) begin failures++; $display("FAIL stall_release_ack got=%b exp=%b", in_ack, 5'b10000); end
    tick();
    checks++; if (in_ack !== 5'b00000) begin failures++; $display("FAIL stall_release_pulse got=%b exp=%b", in_ack, 5'b00000); end
    settle();
  endtask

  task automatic test_overlen();
    logic [N-1:0] e;
    logic         exp_err;
    auto_ack = 1'b1;
    start_pkt(0, 6, 6);
    for (int k = 0; k < 6; k++) exp_q.push_back(5'b00001);
    for (int t = 0; t < 100 && sent[0] < 6; t++) begin
      tick();
      if (tog) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'b00000;
        checks++; if (grant !== e) begin failures++; $display("FAIL ovl_grant got=%b exp=%b", grant, e); end
      end
      if (in_ack[0] === 1'b1) begin
        exp_err = (sent[0] >= 4);
        checks++; if (err_overlen !== exp_err) begin failures++; $display("FAIL ovl_err flit=%0d got=%b exp=%b", sent[0], err_overlen, exp_err); end
      end
      if (sent[0] < 6) begin
        checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL ovl_held got=%b exp=%b", grant, 5'b00001); end
      end
    end
    if (sent[0] != 6) begin
      checks++; failures++;
      $display("FAIL ovl_timeout got=%0d exp=6", sent[0]);
    end
    exp_q.delete();
    settle();
  endtask

  task automatic test_reset_mid();
    int t;
    auto_ack = 1'b1;
    start_pkt(2, 4, 4);
    for (t = 0; t < 40 && sent[2] < 2; t++) tick();
    auto_ack = 1'b0;
    tog      = 1'b0;
    for (t = 0; t < 10 && !tog; t++) tick();
    checks++; if (grant !== 5'b00100) begin failures++; $display("FAIL mid_grant_pre got=%b exp=%b", grant, 5'b00100); end
    #2;
    preset  = 1'b1;
    out_ack = 1'b0;
    req     = '0;
    tail    = '0;
    #1;
    checks++; if (grant !== 5'b00000) begin failures++; $display("FAIL mid_grant got=%b exp=%b", grant, 5'b00000); end
    checks++; if (in_ack !== 5'b00000) begin failures++; $display("FAIL mid_in_ack got=%b exp=%b", in_ack, 5'b00000); end
    checks++; if (out_req !== 1'b0) begin failures++; $display("FAIL mid_out_req got=%b exp=0", out_req); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    checks++; if (err_overlen !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", err_overlen); end
    @(negedge clk);
    preset       = 1'b0;
    prev_out_req = 1'b0;
    clear_model();
    for (int i = 0; i < N; i++) start_pkt(i, 1, 1);
    tick();
    checks++; if (grant !== 5'b00001) begin failures++; $display("FAIL mid_rearb_grant got=%b exp=%b", grant, 5'b00001); end
    checks++; if (out_req !== 1'b1) begin failures++; $display("FAIL mid_rearb_out_req got=%b exp=1", out_req); end
    auto_ack = 1'b1;
    out_ack  = out_req;
    repeat (25) tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_drain_busy got=%b exp=0", busy); end
    checks++; if (req !== 5'b00000) begin failures++; $display("FAIL mid_drain_req got=%b exp=%b", req, 5'b00000); end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    cyc          = 0;
    preset       = 1'b1;
    req          = '0;
    tail         = '0;
    out_ack      = 1'b0;
    auto_ack     = 1'b0;
    prev_out_req = 1'b0;
    tog          = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_packet_lock();
    test_stall();
    test_overlen();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
